// File: rtl/lcd_num_ctrl_if.sv
// Value-in / LCD-pins-out bundle for the numeric LCD controller.
// The slave side is the controller; the master side feeds values and watches the pins.
interface lcd_num_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    i_valid;
   logic [4*NUM_DIGITS-1:0] i_bcd;
   logic                    i_neg;
   logic                    i_blankLz;
   logic [7:0]              o_lcdData;
   logic                    o_rs;
   logic                    o_wr;
   logic                    o_en;
   logic                    o_busy;
   logic                    o_done;

   modport slave (
      input  i_valid, i_bcd, i_neg, i_blankLz,
      output o_lcdData, o_rs, o_wr, o_en, o_busy, o_done
   );

   modport master (
      output i_valid, i_bcd, i_neg, i_blankLz,
      input  o_lcdData, o_rs, o_wr, o_en, o_busy, o_done
   );
endinterface

// File: rtl/lcd_num_ctrl.sv
// HD44780-class LCD driver: self-run power-up/init, then redraws a signed BCD
// readout with decimal point, degree sign and unit letter whenever a new value is pending.
module lcd_num_ctrl #(
   parameter int         NUM_DIGITS   = 4,
   parameter int         FRAC_DIGITS  = 2,
   parameter int         EN_HIGH_CYC  = 12,
   parameter int         CMD_WAIT_CYC = 2000,
   parameter int         CLR_WAIT_CYC = 80000,
   parameter int         POWERUP_CYC  = 750000,
   parameter logic [7:0] UNIT_CHAR    = 8'h43
) (
   input logic           clk,
   input logic           rst,
   lcd_num_ctrl_if.slave bus
);

   localparam int         HAS_PT     = (FRAC_DIGITS > 0) ? 1 : 0;
   localparam int         INT_DIGITS = NUM_DIGITS - FRAC_DIGITS;
   localparam int         NUM_CHARS  = NUM_DIGITS + 4 + HAS_PT;
   localparam logic [3:0] LAST_CHAR  = 4'(NUM_CHARS - 1);
   localparam logic [3:0] LAST_INIT  = 4'd3;

   typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR, CHARS} state_t;
   typedef enum logic [1:0] {SETUP, EN_HI, HOLD} phase_t;

   state_t                  r_state, w_stateNext;
   phase_t                  r_phase, w_phaseNext;
   logic [31:0]             r_cnt, w_cntNext;
   logic [3:0]              r_idx, w_idxNext;
   logic                    r_pend;
   logic [4*NUM_DIGITS-1:0] r_bufBcd, r_frmBcd;
   logic                    r_bufNeg, r_bufBlz, r_frmNeg, r_frmBlz;
   logic                    w_consume;
   logic                    w_byteEnd;
   logic [7:0]              w_byte, w_char;
   logic [31:0]             w_waitLen;
   logic [7:0]              w_digChar [NUM_DIGITS];

   // Leading-zero blanking stops at the first nonzero digit and never touches the units digit.
   always_comb begin
      logic       allZero;
      logic [3:0] nib;
      allZero = 1'b1;
      nib     = 4'd0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         nib     = r_frmBcd[4*(NUM_DIGITS-1-d) +: 4];
         allZero = allZero & (nib == 4'd0);
         if (nib > 4'd9) w_digChar[d] = 8'h3F;
         else            w_digChar[d] = {4'h3, nib};
         if (r_frmBlz && allZero && (d < INT_DIGITS - 1)) w_digChar[d] = 8'h20;
      end
   end

   always_comb begin
      w_char = UNIT_CHAR;
      if (r_idx == 4'd0)
         w_char = r_frmNeg ? 8'h2D : 8'h20;
      else if ((HAS_PT != 0) && (r_idx == 4'(INT_DIGITS + 1)))
         w_char = 8'h2E;
      else if (r_idx == 4'(NUM_DIGITS + HAS_PT + 1))
         w_char = 8'h20;
      else if (r_idx == 4'(NUM_DIGITS + HAS_PT + 2))
         w_char = 8'hDF;
      else if (r_idx <= 4'(NUM_DIGITS + HAS_PT)) begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_idx == 4'(d + 1 + (((HAS_PT != 0) && (d >= INT_DIGITS)) ? 1 : 0)))
               w_char = w_digChar[d];
         end
      end
   end

   always_comb begin
      w_byte = 8'h00;
      case (r_state)
         INIT: begin
            case (r_idx)
               4'd0:    w_byte = 8'h38;
               4'd1:    w_byte = 8'h0C;
               4'd2:    w_byte = 8'h06;
               default: w_byte = 8'h01;
            endcase
         end
         ADDR:    w_byte = 8'h80;
         CHARS:   w_byte = w_char;
         default: w_byte = 8'h00;
      endcase
   end

   assign w_waitLen = (w_byte == 8'h01) ? 32'(CLR_WAIT_CYC) : 32'(CMD_WAIT_CYC);
   assign w_byteEnd = (r_phase == HOLD) && (r_cnt == w_waitLen - 32'd1);

   always_comb begin
      w_stateNext = r_state;
      w_phaseNext = r_phase;
      w_cntNext   = r_cnt + 32'd1;
      w_idxNext   = r_idx;
      w_consume   = 1'b0;
      case (r_state)
         PWRUP: begin
            if (r_cnt == 32'(POWERUP_CYC - 1)) begin
               w_stateNext = INIT;
               w_phaseNext = SETUP;
               w_cntNext   = 32'd0;
               w_idxNext   = 4'd0;
            end
         end
         IDLE: begin
            w_cntNext = 32'd0;
            if (r_pend) begin
               w_consume   = 1'b1;
               w_stateNext = ADDR;
               w_phaseNext = SETUP;
               w_idxNext   = 4'd0;
            end
         end
         default: begin
            case (r_phase)
               SETUP: begin
                  w_phaseNext = EN_HI;
                  w_cntNext   = 32'd0;
               end
               EN_HI: begin
                  if (r_cnt == 32'(EN_HIGH_CYC - 1)) begin
                     w_phaseNext = HOLD;
                     w_cntNext   = 32'd0;
                  end
               end
               default: begin
                  if (w_byteEnd) begin
                     w_phaseNext = SETUP;
                     w_cntNext   = 32'd0;
                     w_idxNext   = r_idx + 4'd1;
                     if (r_state == INIT && r_idx == LAST_INIT) begin
                        w_stateNext = IDLE;
                        w_idxNext   = 4'd0;
                     end else if (r_state == ADDR) begin
                        w_stateNext = CHARS;
                        w_idxNext   = 4'd0;
                     end else if (r_state == CHARS && r_idx == LAST_CHAR) begin
                        w_stateNext = IDLE;
                        w_idxNext   = 4'd0;
                     end
                  end
               end
            endcase
         end
      endcase
   end

   // A value arriving on the same edge IDLE consumes the buffer wins and stays pending.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= PWRUP;
         r_phase  <= SETUP;
         r_cnt    <= 32'd0;
         r_idx    <= 4'd0;
         r_pend   <= 1'b0;
         r_bufBcd <= '0;
         r_bufNeg <= 1'b0;
         r_bufBlz <= 1'b0;
         r_frmBcd <= '0;
         r_frmNeg <= 1'b0;
         r_frmBlz <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_phase <= w_phaseNext;
         r_cnt   <= w_cntNext;
         r_idx   <= w_idxNext;
         if (bus.i_valid) begin
            r_bufBcd <= bus.i_bcd;
            r_bufNeg <= bus.i_neg;
            r_bufBlz <= bus.i_blankLz;
            r_pend   <= 1'b1;
         end else if (w_consume) begin
            r_pend <= 1'b0;
         end
         if (w_consume) begin
            r_frmBcd <= r_bufBcd;
            r_frmNeg <= r_bufNeg;
            r_frmBlz <= r_bufBlz;
         end
      end
   end

   assign bus.o_lcdData = w_byte;
   assign bus.o_rs      = (r_state == CHARS);
   assign bus.o_wr      = 1'b0;
   assign bus.o_en      = (r_phase == EN_HI);
   assign bus.o_busy    = (r_state != IDLE);
   assign bus.o_done    = (r_state == CHARS) && w_byteEnd && (r_idx == LAST_CHAR);

endmodule
